// File: rtl/i2c_pkg.sv
// Shared constants for the single-byte I2C master: state encoding, quarter phases, R/W codes.
package i2c_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_WDATA    = 4'd4;
  localparam logic [3:0] S_WACK     = 4'd5;
  localparam logic [3:0] S_RDATA    = 4'd6;
  localparam logic [3:0] S_RACK     = 4'd7;
  localparam logic [3:0] S_STOP     = 4'd8;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // bit slots in a full transaction, and in one aborted after the address NACK
  localparam int SLOTS_PER_XFER   = 20;
  localparam int SLOTS_ADDR_ABORT = 11;

endpackage

// File: rtl/i2c_master_if.sv
// Request/response port between the local controller and i2c_master; no latency of its own.
interface i2c_master_if;

  logic [6:0] addr;
  logic [7:0] data_in;
  logic       enable;
  logic       rw;
  logic [7:0] data_out;
  logic       ready;

  modport master (output addr, data_in, enable, rw, input data_out, ready);
  modport slave  (input addr, data_in, enable, rw, output data_out, ready);

endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-tick generator: one-clock tick every DIV clocks plus 2-bit phase; held at zero while run_i=0.
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  output logic       tick_o,
  output logic [1:0] phase_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  assign tick_o  = run_i && (cnt_q == LAST);
  assign phase_o = phase_q;

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (!run_i) begin
      cnt_d   = '0;
      phase_d = Q0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= Q0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: ready low for 80*DIV clocks per request (44*DIV on address NACK when
// I2C_NACK_ABORT_EN is defined); enable is accepted only while ready=1, otherwise dropped.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  i2c_master_if.slave req,
  inout  wire         i2c_sda,
  output logic        i2c_scl
);

  logic [3:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] dout_q, dout_d;
  logic [2:0] bit_q, bit_d;
  logic       rw_q, rw_d;
  logic       tick, sample, slot_end, sda_low, sda_in;
  logic [1:0] phase;

  i2c_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .run_i   (state_q != S_IDLE),
    .tick_o  (tick),
    .phase_o (phase)
  );

  assign sample       = tick && (phase == Q2);
  assign slot_end     = tick && (phase == Q3);
  assign sda_in       = i2c_sda;
  assign i2c_sda      = sda_low ? 1'b0 : 1'bz;
  assign req.ready    = (state_q == S_IDLE);
  assign req.data_out = dout_q;

`ifdef I2C_NACK_ABORT_EN
  logic nack_q, nack_d;
  always_ff @(posedge clk) begin
    if (rst) nack_q <= 1'b0;
    else     nack_q <= nack_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    bit_d   = bit_q;
    rw_d    = rw_q;
`ifdef I2C_NACK_ABORT_EN
    nack_d  = nack_q;
`endif
    case (state_q)
      S_IDLE: if (req.enable) begin
        state_d = S_START;
        shift_d = {req.addr, req.rw};
        wdata_d = req.data_in;
        rw_d    = req.rw;
        bit_d   = 3'd0;
      end
      S_START: if (slot_end) state_d = S_ADDR;
      S_ADDR, S_WDATA: if (slot_end) begin
        shift_d = {shift_q[6:0], 1'b0};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WACK;
      end
      S_ADDR_ACK: begin
`ifdef I2C_NACK_ABORT_EN
        if (sample) nack_d = sda_in;
`endif
        if (slot_end) begin
          if (rw_q == RW_READ) begin
            state_d = S_RDATA;
          end else begin
            state_d = S_WDATA;
            shift_d = wdata_q;
          end
`ifdef I2C_NACK_ABORT_EN
          if (nack_q) state_d = S_STOP;
`endif
        end
      end
      // a data NACK has nowhere shorter to go than STOP, so WACK needs no abort path
      S_WACK: if (slot_end) state_d = S_STOP;
      S_RDATA: begin
        if (sample) shift_d = {shift_q[6:0], sda_in};
        if (slot_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_RACK;
        end
      end
      S_RACK: if (slot_end) begin
        dout_d  = shift_q;
        state_d = S_STOP;
      end
      S_STOP: if (slot_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // START keeps SCL high from idle and drops SDA mid-slot; STOP mirrors it
  always_comb begin
    i2c_scl = 1'b1;
    sda_low = 1'b0;
    case (state_q)
      S_START: begin
        i2c_scl = (phase != Q3);
        sda_low = (phase == Q2) || (phase == Q3);
      end
      S_STOP: begin
        i2c_scl = (phase != Q0);
        sda_low = (phase == Q0) || (phase == Q1);
      end
      S_ADDR, S_WDATA: begin
        i2c_scl = (phase == Q1) || (phase == Q2);
        sda_low = !shift_q[7];
      end
      S_ADDR_ACK, S_WACK, S_RDATA, S_RACK: begin
        i2c_scl = (phase == Q1) || (phase == Q2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= 8'h00;
      wdata_q <= 8'h00;
      dout_q  <= 8'h00;
      bit_q   <= 3'd0;
      rw_q    <= RW_WRITE;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      bit_q   <= bit_d;
      rw_q    <= rw_d;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: three DUTs (DIV=2,1,5) share one bus-level slave/monitor selected by sel.
module tb_i2c_master;

  localparam logic [6:0] SLV_ADDR = 7'h2A;
`ifdef I2C_NACK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel = 2'd0;
  logic [6:0] addr = 7'h00;
  logic [7:0] data_in = 8'h00;
  logic [7:0] rd_byte = 8'h00;
  logic       rw = 1'b0;
  logic       enable = 1'b0;
  logic       mon_clr = 1'b0;
  logic [7:0] exp_dout [3];
  int         n_tests = 0;
  int         n_fail = 0;

  wire  sda0, sda1, sda2;
  logic scl0, scl1, scl2;
  pullup (sda0);
  pullup (sda1);
  pullup (sda2);

  i2c_master_if ifc0 ();
  i2c_master_if ifc1 ();
  i2c_master_if ifc2 ();

  assign ifc0.addr = addr;  assign ifc0.data_in = data_in;  assign ifc0.rw = rw;
  assign ifc1.addr = addr;  assign ifc1.data_in = data_in;  assign ifc1.rw = rw;
  assign ifc2.addr = addr;  assign ifc2.data_in = data_in;  assign ifc2.rw = rw;
  assign ifc0.enable = enable && (sel == 2'd0);
  assign ifc1.enable = enable && (sel == 2'd1);
  assign ifc2.enable = enable && (sel == 2'd2);

  i2c_master #(.DIV(2)) dut0 (.clk(clk), .rst(rst), .req(ifc0), .i2c_sda(sda0), .i2c_scl(scl0));
  i2c_master #(.DIV(1)) dut1 (.clk(clk), .rst(rst), .req(ifc1), .i2c_sda(sda1), .i2c_scl(scl1));
  i2c_master #(.DIV(5)) dut2 (.clk(clk), .rst(rst), .req(ifc2), .i2c_sda(sda2), .i2c_scl(scl2));

  always #5 clk = ~clk;

  logic       slave_low = 1'b0;
  logic       scl_m, sda_m, ready_m;
  logic [7:0] dout_m;
  assign sda0 = (sel == 2'd0 && slave_low) ? 1'b0 : 1'bz;
  assign sda1 = (sel == 2'd1 && slave_low) ? 1'b0 : 1'bz;
  assign sda2 = (sel == 2'd2 && slave_low) ? 1'b0 : 1'bz;
  assign scl_m   = (sel == 2'd0) ? scl0 : (sel == 2'd1) ? scl1 : scl2;
  assign sda_m   = (sel == 2'd0) ? sda0 : (sel == 2'd1) ? sda1 : sda2;
  assign ready_m = (sel == 2'd0) ? ifc0.ready : (sel == 2'd1) ? ifc1.ready : ifc2.ready;
  assign dout_m  = (sel == 2'd0) ? ifc0.data_out : (sel == 2'd1) ? ifc1.data_out : ifc2.data_out;

  // bus-level slave at SLV_ADDR plus monitor, driven only by SCL/SDA edges
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic [7:0] abyte = 8'h00, rx = 8'h00;
  logic       ack1 = 1'b1, ack2 = 1'b1;
  int         nbits = 0, n_start = 0, n_stop = 0, stop_rises = 0;
  int         cyc = 0, rise_t = 0, per_min = 1000, per_max = 0;

  function automatic logic slave_drive(input int nxt);
    logic hit;
    hit = (abyte[7:1] == SLV_ADDR);
    if (nxt == 9) return hit;
    if (nxt >= 10 && nxt <= 17) return hit && abyte[0] && !rd_byte[17 - nxt];
    if (nxt == 18) return hit && !abyte[0];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    cyc   <= cyc + 1;
    scl_p <= scl_m;
    sda_p <= sda_m;
    if (mon_clr) begin
      nbits <= 0; n_start <= 0; n_stop <= 0; stop_rises <= 0;
      slave_low <= 1'b0; per_min <= 1000; per_max <= 0;
    end else if (scl_p && scl_m && sda_p && !sda_m) begin
      n_start <= n_start + 1; nbits <= 0; slave_low <= 1'b0;
    end else if (scl_p && scl_m && !sda_p && sda_m) begin
      n_stop <= n_stop + 1; stop_rises <= nbits; slave_low <= 1'b0;
    end else if (!scl_p && scl_m) begin
      nbits  <= nbits + 1;
      rise_t <= cyc;
      if (nbits > 0) begin
        if (cyc - rise_t < per_min) per_min <= cyc - rise_t;
        if (cyc - rise_t > per_max) per_max <= cyc - rise_t;
      end
      if (nbits + 1 <= 8) abyte <= {abyte[6:0], sda_m};
      else if (nbits + 1 == 9) ack1 <= sda_m;
      else if (nbits + 1 <= 17) rx <= {rx[6:0], sda_m};
      else if (nbits + 1 == 18) ack2 <= sda_m;
    end else if (scl_p && !scl_m) begin
      slave_low <= slave_drive(nbits + 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 1 : 5;
  endfunction

  task automatic xact(input int s, input logic [6:0] a, input logic r, input logic [7:0] d,
                      input logic [7:0] rb, input bit poke, input int rst_at);
    int div, cnt;
    bit match, abort;
    div   = div_of(s);
    match = (a == SLV_ADDR);
    abort = !match && ABORT;
    @(posedge clk); #1;
    sel = 2'(s); addr = a; rw = r; data_in = d; rd_byte = rb; mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    check("accept_ready", 32'(ready_m), 32'd0);
    cnt = 0;
    while (!ready_m && cnt < 200 * div) begin
      @(posedge clk); #1;
      cnt++;
      if (poke && cnt == 20 * div) begin
        enable = 1'b1; data_in = 8'h33;
      end else begin
        enable = 1'b0;
      end
      if (rst_at != 0 && cnt == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_scl", 32'(scl_m), 32'd1);
        check("rst_sda", 32'(sda_m), 32'd1);
        check("rst_ready", 32'(ready_m), 32'd1);
        check("rst_dout", 32'(dout_m), 32'h00);
        for (int k = 0; k < 3; k++) exp_dout[k] = 8'h00;
        return;
      end
    end
    check("ready_len", 32'(cnt), 32'(abort ? 44 * div : 80 * div));
    check("n_start", 32'(n_start), 32'd1);
    check("n_stop", 32'(n_stop), 32'd1);
    check("stop_rises", 32'(stop_rises), abort ? 32'd10 : 32'd19);
    check("addr_byte", 32'({a, r}), 32'(abyte));
    check("addr_ack", 32'(ack1), 32'(!match));
    check("scl_per_min", 32'(per_min), 32'(4 * div));
    check("scl_per_max", 32'(per_max), 32'(4 * div));
    if (!abort && r == 1'b0) begin
      check("wr_byte", 32'(rx), 32'(d));
      check("wr_ack", 32'(ack2), 32'(!match));
    end
    if (!abort && r == 1'b1) begin
      check("rd_nack", 32'(ack2), 32'd1);
      exp_dout[s] = match ? rb : 8'hFF;
    end
    repeat (3) @(posedge clk);
    #1;
    check("dout", 32'(dout_m), 32'(exp_dout[s]));
    check("idle_after", 32'(ready_m), 32'd1);
    check("one_start", 32'(n_start), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) exp_dout[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      check("reset_ready", 32'(ready_m), 32'd1);
      check("reset_dout", 32'(dout_m), 32'h00);
      check("reset_scl", 32'(scl_m), 32'd1);
      check("reset_sda", 32'(sda_m), 32'd1);
    end
    xact(0, 7'h2A, 1'b0, 8'hAA, 8'h00, 1'b0, 0);
    xact(0, 7'h2A, 1'b1, 8'h00, 8'h5C, 1'b0, 0);
    xact(0, 7'h15, 1'b0, 8'h12, 8'h00, 1'b0, 0);
    xact(0, 7'h15, 1'b1, 8'h00, 8'h99, 1'b0, 0);
    xact(0, 7'h2A, 1'b0, 8'hAA, 8'h00, 1'b1, 0);
    xact(0, 7'h2A, 1'b1, 8'h00, 8'hC3, 1'b0, 0);
    xact(0, 7'h2A, 1'b0, 8'h11, 8'h00, 1'b0, 26);
    xact(0, 7'h2A, 1'b0, 8'h77, 8'h00, 1'b0, 0);
    xact(1, 7'h2A, 1'b1, 8'h00, 8'hA5, 1'b0, 0);
    xact(1, 7'h15, 1'b0, 8'h3C, 8'h00, 1'b0, 0);
    xact(2, 7'h2A, 1'b0, 8'h5A, 8'h00, 1'b0, 0);
    xact(2, 7'h2A, 1'b1, 8'h00, 8'h81, 1'b0, 0);
    for (int i = 0; i < 14; i++) begin
      xact(int'($urandom_range(0, 2)),
           ($urandom_range(0, 1) == 0) ? SLV_ADDR : 7'($urandom_range(0, 127)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 1'b0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
